// File: rtl/main_mul_acc_pkg.sv
// Shared types and constants for the multiplier-product stream accumulator.
// Build option: MAIN_MUL_ACC_SAT_EN selects saturating instead of wrapping accumulation.
package main_mul_acc_pkg;

    localparam int PROD_WIDTH_DEF = 7;
    localparam int ACC_WIDTH_DEF  = 16;
    localparam int LEN_WIDTH_DEF  = 8;

    // Saturation ceiling for the default accumulator width.
    localparam logic [ACC_WIDTH_DEF-1:0] ACC_MAX = {ACC_WIDTH_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/main_mul_acc_stream_if.sv
// Control, product and sum channels of the stream accumulator.
// master = upstream/consumer side, slave = accumulator side.
interface main_mul_acc_stream_if
    import main_mul_acc_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic                  busy;
    logic [PROD_WIDTH-1:0] prod_dat;
    logic                  prod_vld;
    logic                  prod_rdy;
    logic [ACC_WIDTH-1:0]  sum_dat;
    logic                  sum_vld;
    logic                  sum_rdy;
    logic                  sum_ovf;

    modport master (
        output start, len, prod_dat, prod_vld, sum_rdy,
        input  busy, prod_rdy, sum_dat, sum_vld, sum_ovf
    );

    modport slave (
        input  start, len, prod_dat, prod_vld, sum_rdy,
        output busy, prod_rdy, sum_dat, sum_vld, sum_ovf
    );

endinterface

// File: rtl/main_mul_acc_add.sv
// Combinational accumulator adder: acc + zero-extended product, with carry-out.
// With MAIN_MUL_ACC_SAT_EN defined the result clamps to all-ones on carry; since
// products are unsigned, a clamped accumulator stays clamped for the rest of a burst.
module main_mul_acc_add
    import main_mul_acc_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic [ACC_WIDTH-1:0]  acc_i,
    input  logic [PROD_WIDTH-1:0] prod_i,
    output logic [ACC_WIDTH-1:0]  sum_o,
    output logic                  carry_o
);

    logic [ACC_WIDTH:0] raw;

    // Full-width add with carry-out, then optional clamp.
    always_comb begin
        raw     = {1'b0, acc_i} + {{(ACC_WIDTH+1-PROD_WIDTH){1'b0}}, prod_i};
        carry_o = raw[ACC_WIDTH];
`ifdef MAIN_MUL_ACC_SAT_EN
        sum_o   = raw[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : raw[ACC_WIDTH-1:0];
`else
        sum_o   = raw[ACC_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/main_mul_acc_stream.sv
// Streaming accumulator: sums a burst of len unsigned products and emits one
// registered sum per burst. All outputs are registers, so there is no
// combinational path from prod_vld to prod_rdy or from sum_rdy to sum_vld.
// Build option: MAIN_MUL_ACC_SAT_EN (saturate on overflow instead of wrapping).
module main_mul_acc_stream
    import main_mul_acc_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    main_mul_acc_stream_if.slave  bus
);

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, prod_rdy_q, sum_vld_q, sum_ovf_q;
    logic [ACC_WIDTH-1:0]  sum_dat_q, sum_dat_d;
    logic [ACC_WIDTH-1:0]  add_sum;
    logic                  add_carry;
    logic                  prod_fire;
    logic                  sum_fire;

    main_mul_acc_add #(
        .PROD_WIDTH (PROD_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_add (
        .acc_i   (acc_q),
        .prod_i  (bus.prod_dat),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    assign prod_fire = bus.prod_vld && prod_rdy_q;
    assign sum_fire  = bus.sum_rdy && sum_vld_q;

    // Next-state, accumulator and count update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = bus.len;
                    state_d = (bus.len != '0) ? ACC : OUT;
                end
            end
            ACC: begin
                if (prod_fire) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_carry;
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (sum_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Sum output is only meaningful while presented; park it at zero otherwise.
        sum_dat_d = (state_d == OUT) ? acc_d : '0;
    end

    // State, datapath and registered output updates.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            prod_rdy_q <= 1'b0;
            sum_vld_q  <= 1'b0;
            sum_ovf_q  <= 1'b0;
            sum_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            busy_q     <= (state_d != IDLE);
            prod_rdy_q <= (state_d == ACC);
            sum_vld_q  <= (state_d == OUT);
            sum_ovf_q  <= (state_d == OUT) && ovf_d;
            sum_dat_q  <= sum_dat_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.prod_rdy = prod_rdy_q;
    assign bus.sum_vld  = sum_vld_q;
    assign bus.sum_ovf  = sum_ovf_q;
    assign bus.sum_dat  = sum_dat_q;

endmodule

// File: tb/tb_main_mul_acc_stream.sv
// Bench for main_mul_acc_stream: two instances (16-bit and 8-bit accumulator)
// share one stimulus; expected sums come from the plain arithmetic total of each burst.
module tb_main_mul_acc_stream;

    logic       ap_clk = 1'b0;
    logic       ap_rst;
    logic       start;
    logic [7:0] len;
    logic [6:0] prod_dat;
    logic       prod_vld;
    logic       sum_rdy;

    int checks = 0;
    int errors = 0;
    int prods[$];

    always #5 ap_clk = ~ap_clk;

    main_mul_acc_stream_if #(.PROD_WIDTH(7), .ACC_WIDTH(16), .LEN_WIDTH(8)) i16 ();
    main_mul_acc_stream_if #(.PROD_WIDTH(7), .ACC_WIDTH(8),  .LEN_WIDTH(8)) i8 ();

    assign i16.start = start;    assign i8.start = start;
    assign i16.len = len;        assign i8.len = len;
    assign i16.prod_dat = prod_dat; assign i8.prod_dat = prod_dat;
    assign i16.prod_vld = prod_vld; assign i8.prod_vld = prod_vld;
    assign i16.sum_rdy = sum_rdy;   assign i8.sum_rdy = sum_rdy;

    main_mul_acc_stream #(.PROD_WIDTH(7), .ACC_WIDTH(16), .LEN_WIDTH(8)) u16 (
        .ap_clk (ap_clk), .ap_rst (ap_rst), .bus (i16));
    main_mul_acc_stream #(.PROD_WIDTH(7), .ACC_WIDTH(8), .LEN_WIDTH(8)) u8 (
        .ap_clk (ap_clk), .ap_rst (ap_rst), .bus (i8));

    typedef struct {
        int     n;
        int     p[4];
        int     gap;
        int     wait_c;
        bit     noise;
        longint e16;
        longint e8w;
        longint e8s;
        bit     o8;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic eb, input logic er, input logic ev,
                           input longint d16, input logic o16, input longint d8, input logic o8);
        check({tag, ".busy16"}, i16.busy, eb);
        check({tag, ".busy8"}, i8.busy, eb);
        check({tag, ".prod_rdy"}, {i16.prod_rdy, i8.prod_rdy}, {er, er});
        check({tag, ".sum_vld"}, {i16.sum_vld, i8.sum_vld}, {ev, ev});
        check({tag, ".sum_ovf16"}, i16.sum_ovf, ev ? o16 : 1'b0);
        check({tag, ".sum_ovf8"}, i8.sum_ovf, ev ? o8 : 1'b0);
        if (ev) begin
            check({tag, ".sum_dat16"}, i16.sum_dat, d16);
            check({tag, ".sum_dat8"}, i8.sum_dat, d8);
        end
    endtask

    // Expected 8-bit-accumulator result for a true (unbounded) burst total.
    function automatic longint exp8(input longint tot);
`ifdef MAIN_MUL_ACC_SAT_EN
        return (tot > 255) ? 255 : tot;
`else
        return tot % 256;
`endif
    endfunction

    // Runs one burst using the products queued in prods.
    task automatic do_burst(input int n, input int gap, input int wait_c, input bit noise,
                            input longint e16, input logic o16, input longint e8, input logic o8);
        int idx;
        int budget;
        start = 1'b1;
        len = 8'(n);
        prod_vld = 1'b0;
        sum_rdy = 1'b0;
        tick();
        start = 1'b0;
        idx = 0;
        budget = 0;
        while (idx < n && budget < 4 * n + 20) begin
            check("acc.prod_rdy", {i16.prod_rdy, i8.prod_rdy}, 2'b11);
            check("acc.sum_vld", {i16.sum_vld, i8.sum_vld}, 2'b00);
            prod_vld = ($urandom_range(0, 99) >= gap);
            prod_dat = 7'(prods[idx]);
            if (noise) begin
                start = ($urandom_range(0, 3) == 0);
                len = 8'($urandom);
            end
            tick();
            start = 1'b0;
            if (prod_vld) idx++;
            budget++;
        end
        if (idx < n) check("burst_timeout", idx, n);
        prod_vld = 1'b0;
        for (int w = 0; w <= wait_c; w++) begin
            chk_all("out", 1'b1, 1'b0, 1'b1, e16, o16, e8, o8);
            sum_rdy = (w == wait_c);
            if (noise) begin
                start = 1'b1;
                len = 8'($urandom);
            end
            prod_vld = noise;
            tick();
            start = 1'b0;
            prod_vld = 1'b0;
        end
        sum_rdy = 1'b0;
        chk_all("idle", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        longint tot;
        int     n;
        ap_rst = 1'b1;
        start = 1'b0;
        len = '0;
        prod_dat = '0;
        prod_vld = 1'b0;
        sum_rdy = 1'b0;
        repeat (2) tick();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        check("reset.sum_dat16", i16.sum_dat, 0);
        check("reset.sum_dat8", i8.sum_dat, 0);
        ap_rst = 1'b0;
        tick();

        // Reset mid-burst after 3 accepted products.
        start = 1'b1;
        len = 8'd6;
        tick();
        start = 1'b0;
        prod_vld = 1'b1;
        prod_dat = 7'd50;
        repeat (3) tick();
        ap_rst = 1'b1;
        repeat (2) tick();
        chk_all("rst_mid", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        check("rst_mid.sum_dat16", i16.sum_dat, 0);
        ap_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_all("post_rst", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        end
        prod_vld = 1'b0;

        vecs[0] = '{4, '{10, 20, 30, 127}, 0,  0, 1'b0, 187, 187, 187, 1'b0};
        vecs[1] = '{2, '{5, 6, 0, 0},      40, 5, 1'b0, 11,  11,  11,  1'b0};
        vecs[2] = '{0, '{0, 0, 0, 0},      0,  0, 1'b0, 0,   0,   0,   1'b0};
        vecs[3] = '{3, '{127, 127, 10, 0}, 0,  0, 1'b0, 264, 8,   255, 1'b1};
        vecs[4] = '{3, '{127, 127, 1, 0},  20, 1, 1'b1, 255, 255, 255, 1'b0};
        vecs[5] = '{3, '{127, 127, 2, 0},  0,  2, 1'b1, 256, 0,   255, 1'b1};
        vecs[6] = '{4, '{127, 127, 127, 127}, 10, 0, 1'b1, 508, 252, 255, 1'b1};
        vecs[7] = '{1, '{0, 0, 0, 0},      0,  1, 1'b0, 0,   0,   0,   1'b0};

        foreach (vecs[v]) begin
            prods.delete();
            for (int i = 0; i < 4; i++) prods.push_back(vecs[v].p[i]);
`ifdef MAIN_MUL_ACC_SAT_EN
            do_burst(vecs[v].n, vecs[v].gap, vecs[v].wait_c, vecs[v].noise,
                     vecs[v].e16, 1'b0, vecs[v].e8s, vecs[v].o8);
`else
            do_burst(vecs[v].n, vecs[v].gap, vecs[v].wait_c, vecs[v].noise,
                     vecs[v].e16, 1'b0, vecs[v].e8w, vecs[v].o8);
`endif
            tick();
        end

        for (int r = 0; r < 25; r++) begin
            prods.delete();
            n = (r == 0) ? 255 : $urandom_range(0, 30);
            tot = 0;
            for (int i = 0; i < n; i++) begin
                prods.push_back((r == 0) ? 127 : $urandom_range(0, 127));
                tot += prods[i];
            end
            do_burst(n, (r == 0) ? 0 : $urandom_range(0, 50), $urandom_range(0, 3), r[0],
                     tot % 65536, tot > 65535, exp8(tot), tot > 255);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
